// File: rtl/mul_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_sched: two-requester round-robin front end on an iterative radix-4     |
// | Booth signed 32x32->64 multiplier (sign-magnitude, one digit per cycle).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [63:0] resp_c,
  output logic        busy
);

  localparam logic [1:0] C_ST_IDLE = 2'd0;
  localparam logic [1:0] C_ST_CALC = 2'd1;
  localparam logic [1:0] C_ST_SIGN = 2'd2;
  localparam logic [1:0] C_ST_DONE = 2'd3;

  localparam logic [4:0] C_K_LAST = 5'd16;

  logic [1:0]  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        rst_done_q, rst_done_d;
  logic        sign_q, sign_d;
  logic [31:0] ma_q, ma_d;
  logic [31:0] mb_q, mb_d;
  logic [65:0] acc_q, acc_d;
  logic [4:0]  k_q, k_d;
  logic        id_q, id_d;
  logic [63:0] resp_c_q, resp_c_d;

  logic        w_idle_open;
  logic        w_accept;
  logic        w_sel_id;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;

  logic [34:0] w_ma_ext;
  logic [5:0]  w_bidx;
  logic [2:0]  w_triple;
  logic        w_pp_neg;
  logic        w_pp_dbl;
  logic        w_pp_zero;
  logic [65:0] w_pp_mag;
  logic [65:0] w_pp_shift;
  logic [65:0] w_pp;
  logic [63:0] w_neg_prod;
  logic        w_unused_acc_hi;

  // The cycle right after reset never accepts, so a request raised together
  // with rst_n is only seen once reset has been observed released at an edge.
  assign w_idle_open = (state_q == C_ST_IDLE) && rst_n && rst_done_q;

  assign req0_ready = w_idle_open && req0_valid && (!req1_valid || last_grant_q);
  assign req1_ready = w_idle_open && req1_valid && (!req0_valid || !last_grant_q);

  assign w_accept = req0_ready || req1_ready;
  assign w_sel_id = req1_ready;
  assign w_sel_a  = w_sel_id ? req1_a : req0_a;
  assign w_sel_b  = w_sel_id ? req1_b : req0_b;

  // Negating 0x80000000 in 32 bits yields 0x80000000, which is 2^31 unsigned.
  assign w_abs_a = w_sel_a[31] ? (32'd0 - w_sel_a) : w_sel_a;
  assign w_abs_b = w_sel_b[31] ? (32'd0 - w_sel_b) : w_sel_b;

  assign w_ma_ext = {2'b00, ma_q, 1'b0};
  assign w_bidx   = {k_q, 1'b0};
  assign w_triple = w_ma_ext[w_bidx +: 3];

  always_comb begin
    w_pp_neg  = 1'b0;
    w_pp_dbl  = 1'b0;
    w_pp_zero = 1'b0;
    case (w_triple)
      3'b001, 3'b010: begin
        w_pp_neg = 1'b0;
      end
      3'b011: begin
        w_pp_dbl = 1'b1;
      end
      3'b100: begin
        w_pp_neg = 1'b1;
        w_pp_dbl = 1'b1;
      end
      3'b101, 3'b110: begin
        w_pp_neg = 1'b1;
      end
      default: begin
        w_pp_zero = 1'b1;
      end
    endcase
  end

  assign w_pp_mag   = w_pp_dbl ? {33'd0, mb_q, 1'b0} : {34'd0, mb_q};
  assign w_pp_shift = w_pp_mag << w_bidx;
  assign w_pp       = w_pp_zero ? 66'd0 :
                      (w_pp_neg ? (66'd0 - w_pp_shift) : w_pp_shift);

  // The final magnitude fits in 63 bits, so the top guard bits carry no result.
  assign w_neg_prod      = 64'd0 - acc_q[63:0];
  assign w_unused_acc_hi = ^acc_q[65:64];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rst_done_d   = 1'b1;
    sign_d       = sign_q;
    ma_d         = ma_q;
    mb_d         = mb_q;
    acc_d        = acc_q;
    k_d          = k_q;
    id_d         = id_q;
    resp_c_d     = resp_c_q;

    case (state_q)
      C_ST_IDLE: begin
        if (w_accept) begin
          sign_d       = w_sel_a[31] ^ w_sel_b[31];
          ma_d         = w_abs_a;
          mb_d         = w_abs_b;
          acc_d        = 66'd0;
          k_d          = 5'd0;
          id_d         = w_sel_id;
          last_grant_d = w_sel_id;
          state_d      = C_ST_CALC;
        end
      end
      C_ST_CALC: begin
        acc_d = acc_q + w_pp;
        if (k_q == C_K_LAST) begin
          state_d = C_ST_SIGN;
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      C_ST_SIGN: begin
        resp_c_d = sign_q ? w_neg_prod : acc_q[63:0];
        state_d  = C_ST_DONE;
      end
      C_ST_DONE: begin
        if (resp_ready) begin
          state_d = C_ST_IDLE;
        end
      end
      default: begin
        state_d = C_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= C_ST_IDLE;
      last_grant_q <= 1'b1;
      rst_done_q   <= 1'b0;
      sign_q       <= 1'b0;
      ma_q         <= 32'd0;
      mb_q         <= 32'd0;
      acc_q        <= 66'd0;
      k_q          <= 5'd0;
      id_q         <= 1'b0;
      resp_c_q     <= 64'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rst_done_q   <= rst_done_d;
      sign_q       <= sign_d;
      ma_q         <= ma_d;
      mb_q         <= mb_d;
      acc_q        <= acc_d;
      k_q          <= k_d;
      id_q         <= id_d;
      resp_c_q     <= resp_c_d;
    end
  end

  assign resp_valid = (state_q == C_ST_DONE);
  assign resp_id    = id_q;
  assign resp_c     = resp_c_q;
  assign busy       = (state_q != C_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_sched: directed bench for mul_sched (table vectors + corner cases). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mul_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [63:0] resp_c;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[11];

  mul_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_c     (resp_c),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  // Entered just after the accept edge (cycle 1); returns at the negedge of
  // the first resp_valid cycle, lat being that cycle number.
  task automatic wait_resp(output logic [63:0] c, output bit id, output int lat,
                           output bit rdy_seen);
    c = 64'd0; id = 1'b0; lat = -1; rdy_seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) rdy_seen = 1'b1;
      if (resp_valid) begin
        c = resp_c; id = resp_id; lat = n;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] c, output bit id, output int lat);
    bit got;
    bit seen;
    got = 1'b0;
    if (sel) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else     begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sel ? req1_ready : req0_ready) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (got) begin
      wait_resp(c, id, lat, seen);
    end else begin
      c = 64'd0; id = 1'b0; lat = -1;
    end
    @(posedge clk); #1;
  endtask

  logic [63:0] c;
  bit          id;
  int          lat;
  bit          seen;
  bit          ok;

  initial begin
    vecs[0]  = '{1'b0, 32'd3,        32'd5,        64'd15};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd6,        64'hFFFFFFFFFFFFFFD6};
    vecs[2]  = '{1'b1, 32'd0,        32'hFFFFFFFB, 64'd0};
    vecs[3]  = '{1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[4]  = '{1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF80000000};
    vecs[5]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1};
    vecs[7]  = '{1'b0, 32'h12345678, 32'hFFFFFFFE, 64'hFFFFFFFFDB975310};
    vecs[8]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h0000000080000000};
    vecs[9]  = '{1'b0, 32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[10] = '{1'b0, 32'd1000,     32'hFFFFFC18, 64'hFFFFFFFFFFF0BDC0};

    rst_n = 1'b0; resp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;

    // Reset state, with both requesters already asserting valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req0_ready", 64'(req0_ready), 64'd0);
    chk("rst_req1_ready", 64'(req1_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_resp_id",    64'(resp_id),    64'd0);
    chk("rst_resp_c",     resp_c,          64'd0);

    // Release: no accept in the release cycle, req0 wins the first tie.
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_a = 32'd2; req0_b = 32'd3; req1_a = 32'd4; req1_b = 32'd5;
    @(negedge clk);
    chk("release_req0_ready", 64'(req0_ready), 64'd0);
    chk("release_req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb1_req0_ready", 64'(req0_ready), 64'd1);
    chk("arb1_req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_resp(c, id, lat, seen);
    chk("arb1_c",   c,          64'd6);
    chk("arb1_id",  64'(id),    64'd0);
    chk("arb1_lat", 64'(lat),   64'd19);
    chk("arb1_no_ready_while_busy", 64'(seen), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb2_busy_low",   64'(busy),       64'd0);
    chk("arb2_req1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(c, id, lat, seen);
    chk("arb2_c",   c,        64'd20);
    chk("arb2_id",  64'(id),  64'd1);
    chk("arb2_lat", 64'(lat), 64'd19);
    @(posedge clk); #1;

    // Tie again: req0 should win because req1 was granted last.
    req0_a = 32'd7; req0_b = 32'd8; req1_a = 32'd9; req1_b = 32'd10;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    chk("arb3_req0_ready", 64'(req0_ready), 64'd1);
    chk("arb3_req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_resp(c, id, lat, seen);
    chk("arb3_c",  c,       64'd56);
    chk("arb3_id", 64'(id), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arb4_req1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_resp(c, id, lat, seen);
    chk("arb4_c",  c,       64'd90);
    chk("arb4_id", 64'(id), 64'd1);
    @(posedge clk); #1;

    // Backpressure: five stalled cycles in DONE with noisy requester inputs.
    resp_ready = 1'b0;
    req0_a = 32'd11; req0_b = 32'd13; req0_valid = 1'b1;
    @(negedge clk);
    chk("bp_req0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_resp(c, id, lat, seen);
    chk("bp_c",   c,        64'd143);
    chk("bp_lat", 64'(lat), 64'd19);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'(i); req0_b = 32'(i + 1);
      req1_a = 32'd6;  req1_b = 32'd7;
      @(negedge clk);
      ok = resp_valid && (resp_c == 64'd143) && (resp_id == 1'b0) && busy &&
           !req0_ready && !req1_ready;
      chk("bp_hold", 64'(ok), 64'd1);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_after_req1_ready", 64'(req1_ready), 64'd1);
    chk("bp_after_req0_ready", 64'(req0_ready), 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp(c, id, lat, seen);
    chk("bp_after_c",  c,       64'd42);
    chk("bp_after_id", 64'(id), 64'd1);
    @(posedge clk); #1;

    // Reset pulse in the middle of CALC discards the operation.
    req1_a = 32'd100; req1_b = 32'd100; req1_valid = 1'b1;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_busy",       64'(busy),       64'd0);
    chk("midrst_resp_c",     resp_c,          64'd0);
    chk("midrst_resp_id",    64'(resp_id),    64'd0);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("midrst_no_resp", 64'(seen), 64'd0);
    @(posedge clk); #1;
    do_op(1'b0, 32'd9, 32'd9, c, id, lat);
    chk("midrst_after_c",   c,        64'd81);
    chk("midrst_after_id",  64'(id),  64'd0);
    chk("midrst_after_lat", 64'(lat), 64'd19);

    // Table-driven products.
    for (int v = 0; v < 11; v++) begin
      do_op(vecs[v].sel, vecs[v].a, vecs[v].b, c, id, lat);
      chk($sformatf("vec%0d_c", v),   c,        vecs[v].exp);
      chk($sformatf("vec%0d_id", v),  64'(id),  64'(vecs[v].sel));
      chk($sformatf("vec%0d_lat", v), 64'(lat), 64'd19);
      @(negedge clk);
      chk($sformatf("vec%0d_busy_after", v), 64'(busy), 64'd0);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
